// File: rtl/parking_capacity_tracker.sv
// Free-space counter and entry-gate controller for the parking lot.
// Sensors are edge-detected; the gate stays open GATE_CYCLES cycles per admitted car, longer while a car lingers.
module parking_capacity_tracker #(
    parameter int unsigned TOTAL_SPACES = 200,
    parameter int unsigned GATE_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry,
    input  logic       exit,
    input  logic       enable,
    output logic [7:0] parking_capacity,
    output logic       full,
    output logic       gate_open,
    output logic       exit_error
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        HOLD
    } state_t;

    localparam logic [7:0] TOTAL     = 8'(TOTAL_SPACES);
    localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] cap_q, cap_d;
    logic       entry_q, exit_q;
    logic       gate_q, gate_d;
    logic       err_q, err_d;

    logic       entry_rise, exit_rise;
    logic       admit, exit_valid;

    always_comb begin
        entry_rise = entry & ~entry_q;
        exit_rise  = exit & ~exit_q;
        // Capacity and IDLE guards are local so a bad grant can never underflow the count.
        admit      = entry_rise & enable & (cap_q != '0) & (state_q == IDLE);
        exit_valid = exit_rise & (cap_q != TOTAL);
        err_d      = exit_rise & (cap_q == TOTAL);

        cap_d = cap_q;
        if (admit && !exit_valid) begin
            cap_d = cap_q - 8'd1;
        end else if (exit_valid && !admit) begin
            cap_d = cap_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (admit) begin
                    state_d = OPEN;
                    timer_d = GATE_LOAD;
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    state_d = entry ? HOLD : IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            HOLD: begin
                if (!entry) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gate_d = (state_d != IDLE);
    end

    // Sensor copies load the live level during reset so a held sensor yields no edge on release.
    always_ff @(posedge clk) begin
        entry_q <= entry;
        exit_q  <= exit;
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            cap_q   <= TOTAL;
            gate_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cap_q   <= cap_d;
            gate_q  <= gate_d;
            err_q   <= err_d;
        end
    end

    assign parking_capacity = cap_q;
    assign full             = (cap_q == '0);
    assign gate_open        = gate_q;
    assign exit_error       = err_q;

endmodule

// File: tb/tb_parking_capacity_tracker.sv
// Bench for parking_capacity_tracker: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the lot.
module tb_parking_capacity_tracker;

    localparam int TOT = 3;
    localparam int G   = 4;

    logic       clk = 1'b0;
    logic       reset, entry, exit_s, enable;
    logic [7:0] parking_capacity;
    logic       full, gate_open, exit_error;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_cap, m_left;
    bit m_hold, m_err, m_pe, m_px;

    parking_capacity_tracker #(.TOTAL_SPACES(TOT), .GATE_CYCLES(G)) dut (
        .clk              (clk),
        .reset            (reset),
        .entry            (entry),
        .exit             (exit_s),
        .enable           (enable),
        .parking_capacity (parking_capacity),
        .full             (full),
        .gate_open        (gate_open),
        .exit_error       (exit_error)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] model_vec();
        return {8'(m_cap), (m_cap == 0), (m_left > 0 || m_hold), m_err};
    endfunction

    // Apply one cycle of inputs, advance the model on the same edge, sample 1 time unit later.
    task automatic step(input bit e, input bit x, input bit en, input bit r);
        bit er, xr, adm, xv;
        entry = e; exit_s = x; enable = en; reset = r;
        @(posedge clk);
        if (r) begin
            m_cap = TOT; m_left = 0; m_hold = 0; m_err = 0;
        end else begin
            er  = e && !m_pe;
            xr  = x && !m_px;
            adm = er && en && m_cap > 0 && m_left == 0 && !m_hold;
            xv  = xr && m_cap < TOT;
            m_err = xr && m_cap == TOT;
            m_cap = m_cap - int'(adm) + int'(xv);
            if (adm) m_left = G;
            else if (m_left > 0) begin
                if (m_left == 1 && e) m_hold = 1;
                m_left--;
            end else if (m_hold && !e) m_hold = 0;
        end
        m_pe = e; m_px = x;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
        vectors++;
        if ({parking_capacity, full, gate_open, exit_error} !== {8'd3, 3'b000}) begin
            miscompares++;
            $display("FAIL reset: got cap=%0d full=%b gate=%b err=%b, want cap=3 full=0 gate=0 err=0",
                     parking_capacity, full, gate_open, exit_error);
        end
    endtask

    task automatic test_single_admit();
        int gate_cycles = 0;
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        vectors++;
        if (parking_capacity !== 8'd2 || gate_open !== 1'b1) begin
            miscompares++;
            $display("FAIL single_admit_first: got cap=%0d gate=%b, want cap=2 gate=1", parking_capacity, gate_open);
        end
        gate_cycles = 1;
        for (int i = 0; i < 9; i++) begin
            step(i < 1, 0, 0, 0);
            vectors++;
            if ({parking_capacity, full, gate_open, exit_error} !== model_vec()) begin
                miscompares++;
                $display("FAIL single_admit cyc%0d: got %h, want %h", i, {parking_capacity, full, gate_open, exit_error}, model_vec());
            end
            gate_cycles += int'(gate_open);
        end
        vectors++;
        if (gate_cycles != G) begin
            miscompares++;
            $display("FAIL single_admit_gate_len: got %0d cycles, want %0d", gate_cycles, G);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 1, 0);
            for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        end
        vectors++;
        if (parking_capacity !== 8'd0 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL fill: got cap=%0d full=%b, want cap=0 full=1", parking_capacity, full);
        end
        for (int i = 0; i < 4; i++) begin
            step(i < 2, 0, 1, 0);
            vectors++;
            if (parking_capacity !== 8'd0 || gate_open !== 1'b0 ||
                {parking_capacity, full, gate_open, exit_error} !== model_vec()) begin
                miscompares++;
                $display("FAIL fill_over cyc%0d: got cap=%0d gate=%b, want cap=0 gate=0", i, parking_capacity, gate_open);
            end
        end
    endtask

    task automatic test_empty_exit();
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        vectors++;
        if (exit_error !== 1'b1 || parking_capacity !== 8'd3) begin
            miscompares++;
            $display("FAIL empty_exit: got err=%b cap=%0d, want err=1 cap=3", exit_error, parking_capacity);
        end
        step(0, 1, 0, 0);
        vectors++;
        if (exit_error !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_exit_pulse: got err=%b, want 0", exit_error);
        end
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        vectors++;
        if (exit_error !== 1'b1 || parking_capacity !== 8'd2) begin
            miscompares++;
            $display("FAIL empty_exit_admit: got err=%b cap=%0d, want err=1 cap=2", exit_error, parking_capacity);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        step(0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 1, 0);
            for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        end
        step(1, 1, 1, 0);
        vectors++;
        if (parking_capacity !== 8'd1 || exit_error !== 1'b0) begin
            miscompares++;
            $display("FAIL simultaneous: got cap=%0d err=%b, want cap=1 err=0", parking_capacity, exit_error);
        end
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1, 0);
            vectors++;
            if (gate_open !== 1'b1 || {parking_capacity, full, gate_open, exit_error} !== model_vec()) begin
                miscompares++;
                $display("FAIL hold cyc%0d: got gate=%b cap=%0d, want gate=1 cap=1", i, gate_open, parking_capacity);
            end
        end
        step(0, 0, 0, 0);
        vectors++;
        if (gate_open !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: got gate=%b, want 0", gate_open);
        end
    endtask

    task automatic test_reset_mid_open();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        vectors++;
        if (gate_open !== 1'b0 || parking_capacity !== 8'd3) begin
            miscompares++;
            $display("FAIL reset_mid_open: got gate=%b cap=%0d, want gate=0 cap=3", gate_open, parking_capacity);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0);
            vectors++;
            if (gate_open !== 1'b0 || parking_capacity !== 8'd3) begin
                miscompares++;
                $display("FAIL reset_no_event cyc%0d: got gate=%b cap=%0d, want gate=0 cap=3", i, gate_open, parking_capacity);
            end
        end
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        vectors++;
        if (parking_capacity !== 8'd2 || gate_open !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rearm: got cap=%0d gate=%b, want cap=2 gate=1", parking_capacity, gate_open);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit e = 0, x = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) e = ~e;
            if ($urandom_range(0, 3) == 0) x = ~x;
            step(e, x, $urandom_range(0, 4) != 0, $urandom_range(0, 79) == 0);
            vectors++;
            if ({parking_capacity, full, gate_open, exit_error} !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got cap=%0d full=%b gate=%b err=%b, want vec %h",
                         i, parking_capacity, full, gate_open, exit_error, model_vec());
            end
        end
    endtask

    initial begin
        entry = 0; exit_s = 0; enable = 0; reset = 1;
        m_cap = TOT; m_left = 0; m_hold = 0; m_err = 0; m_pe = 0; m_px = 0;
        test_reset();
        test_single_admit();
        test_fill();
        test_empty_exit();
        test_simultaneous();
        test_reset_mid_open();
        step(0, 0, 0, 1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
